// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount frame accumulator.
// Holds the FSM state type, a width-generic popcount and the default-width result record.
package popcount_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int POP_MAX_W = 32;

    localparam int DEF_IN_W      = 3;
    localparam int DEF_FRAME_LEN = 8;
    localparam int DEF_SUM_W     = $clog2(DEF_FRAME_LEN * DEF_IN_W + 1);
    localparam int DEF_CNT_W     = $clog2(DEF_FRAME_LEN + 1);

    // Frame result at the default parameterisation.
    typedef struct packed {
        logic [DEF_SUM_W-1:0] sum;
        logic [DEF_CNT_W-1:0] beats;
        logic                 short_frame;
    } popacc_result_t;

    // Counts the set bits among the low 'width' bits of 'word'.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] word,
                                             input int unsigned width);
        int unsigned total;
        total = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            if ((i < width) && word[i]) begin
                total = total + 1;
            end
        end
        return total;
    endfunction

endpackage

// File: rtl/popcount_lane.sv
// Combinational IN_W-bit population count lane.
module popcount_lane
    import popcount_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int POP_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  data,
    output logic [POP_W-1:0] count
);

    always_comb begin
        count = POP_W'(popcount(POP_MAX_W'(data), IN_W));
    end

endmodule

// File: rtl/popcount_frame_accum.sv
// Accumulates per-word popcounts over frames of up to FRAME_LEN beats and presents the total.
// Optional macro POPACC_BYPASS_EN lets a new frame start in the cycle the held result is taken.
module popcount_frame_accum
    import popcount_pkg::*;
#(
    parameter int IN_W      = 3,
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = $clog2(FRAME_LEN * IN_W + 1),
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_short
);

    localparam int               POP_W    = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] beats;
        logic             short_frame;
    } result_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    result_t          res_q, res_d;

    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] pop_ext;
    logic             in_fire;
    logic             out_fire;
    logic             closing;

    popcount_lane #(
        .IN_W  (IN_W),
        .POP_W (POP_W)
    ) u_lane (
        .data  (in_data),
        .count (pop)
    );

    assign pop_ext = SUM_W'(pop);

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            if (state_q == ACCUM) begin
                in_ready = 1'b1;
            end else begin
`ifdef POPACC_BYPASS_EN
                in_ready = out_ready;
`else
                in_ready = 1'b0;
`endif
            end
        end
    end

    assign out_valid = (state_q == HOLD);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign closing   = (cnt_q == LAST_CNT) || in_last;

    // acc and cnt are always zero in HOLD, so a bypass beat reuses the ACCUM path.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if ((state_q == HOLD) && out_fire) begin
            state_d = ACCUM;
        end
        if (in_fire) begin
            if (closing) begin
                res_d.sum         = acc_q + pop_ext;
                res_d.beats       = cnt_q + CNT_W'(1);
                res_d.short_frame = (cnt_q != LAST_CNT);
                acc_d             = '0;
                cnt_d             = '0;
                state_d           = HOLD;
            end else begin
                acc_d = acc_q + pop_ext;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign out_sum   = res_q.sum;
    assign out_beats = res_q.beats;
    assign out_short = res_q.short_frame;

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Self-checking bench for popcount_frame_accum: frame-level reference model plus directed literal checks.
module tb_popcount_frame_accum;

    localparam int IN_W      = 3;
    localparam int FRAME_LEN = 8;
    localparam int SUM_W     = 5;
    localparam int CNT_W     = 4;
`ifdef POPACC_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_beats;
    logic             out_short;

    int checks   = 0;
    int failures = 0;

    popcount_frame_accum #(
        .IN_W      (IN_W),
        .FRAME_LEN (FRAME_LEN),
        .SUM_W     (SUM_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_short (out_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: tracks the words of the open frame and the result the block must present.
    bit model_live = 1'b0;
    bit exp_valid  = 1'b0;
    int exp_sum    = 0;
    int exp_beats  = 0;
    bit exp_short  = 1'b0;
    int frame_acc  = 0;
    int frame_beats = 0;

    always @(negedge clk) begin
        bit exp_in_ready;
        bit fo;
        bit fi;
        exp_in_ready = !reset && (!exp_valid || (BYPASS && out_ready));
        if (model_live) begin
            checkOutput("mon_out_valid", out_valid, exp_valid);
            checkOutput("mon_in_ready", in_ready, exp_in_ready);
            checkOutput("mon_out_sum", out_sum, exp_sum);
            checkOutput("mon_out_beats", out_beats, exp_beats);
            checkOutput("mon_out_short", out_short, exp_short);
        end
        if (reset) begin
            exp_valid   = 1'b0;
            exp_sum     = 0;
            exp_beats   = 0;
            exp_short   = 1'b0;
            frame_acc   = 0;
            frame_beats = 0;
            model_live  = 1'b1;
        end else if (model_live) begin
            fo = exp_valid && out_ready;
            fi = in_valid && exp_in_ready;
            if (fo) exp_valid = 1'b0;
            if (fi) begin
                frame_acc   = frame_acc + $countones(in_data);
                frame_beats = frame_beats + 1;
                if ((frame_beats == FRAME_LEN) || in_last) begin
                    exp_sum     = frame_acc;
                    exp_beats   = frame_beats;
                    exp_short   = (frame_beats != FRAME_LEN);
                    exp_valid   = 1'b1;
                    frame_acc   = 0;
                    frame_beats = 0;
                end
            end
        end
    end

    int dut_fires = 0;
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) dut_fires++;
    end

    task automatic syncUp();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and holds it until the block accepts it (bounded).
    task automatic applyStimulus(input bit v, input logic [IN_W-1:0] d, input bit l, input bit r);
        int  waited;
        bit  took;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        if (!v) begin
            syncUp();
        end else begin
            waited = 0;
            took   = 1'b0;
            while (!took && (waited < 32)) begin
                @(negedge clk);
                took = in_ready;
                syncUp();
                waited++;
            end
            checkOutput("beat_accepted_in_budget", took, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int fires0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sum", out_sum, 0);
        checkOutput("rst_out_beats", out_beats, 0);
        checkOutput("rst_out_short", out_short, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        syncUp();

        $display("[TB] full frame of 3'b111");
        repeat (8) applyStimulus(1'b1, 3'b111, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t1_out_valid", out_valid, 1);
        checkOutput("t1_out_sum", out_sum, 24);
        checkOutput("t1_out_beats", out_beats, 8);
        checkOutput("t1_out_short", out_short, 0);
        syncUp();

        $display("[TB] ramp 0..7");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, IN_W'(i), 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t2_out_sum", out_sum, 12);
        checkOutput("t2_out_beats", out_beats, 8);
        syncUp();

        $display("[TB] short frame ended by in_last");
        applyStimulus(1'b1, 3'b101, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'b011, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t3_out_sum", out_sum, 7);
        checkOutput("t3_out_beats", out_beats, 3);
        checkOutput("t3_out_short", out_short, 1);
        syncUp();

        $display("[TB] backpressure hold");
        repeat (8) applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
        in_valid  = 1'b1;
        in_data   = 3'b111;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("t4_out_valid", out_valid, 1);
            checkOutput("t4_out_sum", out_sum, 8);
            checkOutput("t4_out_beats", out_beats, 8);
            checkOutput("t4_in_ready", in_ready, 0);
            syncUp();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        syncUp();

        $display("[TB] reset mid-frame");
        repeat (4) applyStimulus(1'b1, 3'b111, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_in_ready_in_reset", in_ready, 0);
        syncUp();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_out_sum", out_sum, 0);
        checkOutput("t5_out_beats", out_beats, 0);
        syncUp();
        repeat (8) applyStimulus(1'b1, 3'b010, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5_out_sum_after", out_sum, 8);
        checkOutput("t5_out_short", out_short, 0);
        syncUp();

        $display("[TB] streaming two frames of 3'b110");
        fires0 = dut_fires;
        repeat (16) applyStimulus(1'b1, 3'b110, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t6_out_valid", out_valid, 1);
        checkOutput("t6_out_sum", out_sum, 16);
        checkOutput("t6_out_beats", out_beats, 8);
        syncUp();
        checkOutput("t6_result_count", dut_fires - fires0, 2);

        $display("[TB] randomized traffic");
        repeat (600) begin
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = IN_W'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            syncUp();
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) syncUp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
